// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared defaults and state encoding for the CNN image loader
// Purpose: default geometry for the loader and its buffer, plus the loader FSM state type.
// Contents: DEF_IMG_SIZE, DEF_PIX_W, DEF_OUT_W, loader_state_e.
package cnn_pkg;

    localparam int DEF_IMG_SIZE = 64;
    localparam int DEF_PIX_W    = 32;
    localparam int DEF_OUT_W    = 32;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } loader_state_e;

endpackage

// File: rtl/cnn_img_buf.sv
// rtl/cnn_img_buf.sv - IMG_SIZE-entry pixel register file with flattened read-out
// Purpose: holds one image frame; single write port, whole frame visible in parallel.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears every entry
//   we_i     in   write enable
//   waddr_i  in   entry index to write
//   wdata_i  in   pixel to write
//   img_o    out  all entries, entry k at bits [k*PIX_W +: PIX_W]
module cnn_img_buf #(
    parameter int IMG_SIZE = 64,
    parameter int PIX_W    = 32,
    parameter int IDX_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          waddr_i,
    input  logic [PIX_W-1:0]          wdata_i,
    output logic [IMG_SIZE*PIX_W-1:0] img_o
);

    logic [IMG_SIZE-1:0][PIX_W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Packed array: entry 0 sits in the least significant PIX_W bits.
    assign img_o = mem_q;

endmodule

// File: rtl/cnn_img_loader.sv
// rtl/cnn_img_loader.sv - collects a pixel frame, runs the CNN, hands back its prediction
// Purpose: LOAD accepts IMG_SIZE pixels into the buffer, RUN holds cnn_enable with a
//   frozen image until cnn_done, RESULT offers the captured prediction until res_ready.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready  pixel input stream
//   img_out                        flattened frame, pixel k at [k*PIX_W +: PIX_W]
//   cnn_enable, cnn_done, cnn_value  downstream CNN control and result
//   res_valid/res_data/res_ready   prediction output handshake
//   err_len                        one-cycle pulse on frame-length mismatch
//   chk_out                        frame pixel sum (only with CNN_LOADER_CHECKSUM_EN)
// Optional feature macro: CNN_LOADER_CHECKSUM_EN
module cnn_img_loader
    import cnn_pkg::*;
#(
    parameter int IMG_SIZE = DEF_IMG_SIZE,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [PIX_W-1:0]          s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [IMG_SIZE*PIX_W-1:0] img_out,
    output logic                      cnn_enable,
    input  logic                      cnn_done,
    input  logic [OUT_W-1:0]          cnn_value,
    output logic                      res_valid,
    output logic [OUT_W-1:0]          res_data,
    input  logic                      res_ready,
    output logic                      err_len
`ifdef CNN_LOADER_CHECKSUM_EN
    ,
    output logic [PIX_W-1:0]          chk_out
`endif
);

    localparam int IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);

    loader_state_e    state_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic             cnn_enable_q;
    logic             res_valid_q;
    logic [OUT_W-1:0] res_data_q;
    logic             err_len_q;

    logic accept;
    logic last_pix;

    // Ready is forced low during reset so nothing is taken on a reset edge.
    assign s_ready  = (state_q == LOAD) && !rst;
    assign accept   = s_valid && s_ready;
    assign last_pix = (wr_idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wr_idx_q     <= '0;
            cnn_enable_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            err_len_q    <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (last_pix) begin
                            // Full frame: process it even when s_last is missing.
                            wr_idx_q     <= '0;
                            state_q      <= RUN;
                            cnn_enable_q <= 1'b1;
                            err_len_q    <= !s_last;
                        end else if (s_last) begin
                            // Short frame: drop it and start over.
                            wr_idx_q  <= '0;
                            err_len_q <= 1'b1;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnn_done) begin
                        res_data_q   <= cnn_value;
                        res_valid_q  <= 1'b1;
                        cnn_enable_q <= 1'b0;
                        state_q      <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign cnn_enable = cnn_enable_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign err_len    = err_len_q;

    // Writes only happen on accepted pixels, so the image is frozen outside LOAD.
    cnn_img_buf #(
        .IMG_SIZE (IMG_SIZE),
        .PIX_W    (PIX_W),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i (wr_idx_q),
        .wdata_i (s_data),
        .img_o   (img_out)
    );

`ifdef CNN_LOADER_CHECKSUM_EN
    logic [PIX_W-1:0] chk_q;
    logic [PIX_W-1:0] chk_d;

    // The first pixel of a frame restarts the sum; a discarded frame clears it.
    always_comb begin
        chk_d = chk_q;
        if (accept) begin
            if (s_last && !last_pix) begin
                chk_d = '0;
            end else if (wr_idx_q == '0) begin
                chk_d = s_data;
            end else begin
                chk_d = chk_q + s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_out = chk_q;
`endif

endmodule
